w5300_tx_frame_buffer: RTL and testbench

Upstream feeder for the W5300 entry block's TX path. It accepts a 16-bit word stream with a valid/ready/last handshake and stores frames in two ping-pong banks. When a frame is complete, it raises tx_req toward the entry block and serves tx_data from the bank at the address the entry block drives on tx_buffer_addr. A bank is released once the entry block has gone busy and then idle again.

---
 rtl/w5300_tx_frame_buffer_if.sv | 27 ++
 rtl/w5300_tx_frame_buffer.sv | 166 ++++++++++++++++
 tb/tb_w5300_tx_frame_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/w5300_tx_frame_buffer_if.sv
// Word-stream and entry-block TX signals of the W5300 TX frame buffer.
// The master modport is the upstream/entry side; the slave modport is the buffer.
interface w5300_tx_frame_buffer_if #(
    parameter int unsigned AW = 12
);
    logic          s_valid;
    logic [15:0]   s_data;
    logic          s_last;
    logic          s_ready;
    logic          tx_req;
    logic [15:0]   tx_data;
    logic [AW-1:0] tx_buffer_addr;
    logic [AW:0]   tx_len;
    logic          busy_n;
    logic          frame_drop;
    logic          req_timeout;

    modport master (
        output s_valid, s_data, s_last, tx_buffer_addr, busy_n,
        input  s_ready, tx_req, tx_data, tx_len, frame_drop, req_timeout
    );

    modport slave (
        input  s_valid, s_data, s_last, tx_buffer_addr, busy_n,
        output s_ready, tx_req, tx_data, tx_len, frame_drop, req_timeout
    );
endinterface

// File: rtl/w5300_tx_frame_buffer.sv
// Ping-pong frame buffer feeding the W5300 entry block TX path: frames are
// written into two banks and handed out in order through a req/busy_n handshake.
module w5300_tx_frame_buffer #(
    parameter int unsigned TX_BUFFER_ADDR_WIDTH = 12,
    parameter int unsigned REQ_TIMEOUT          = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    w5300_tx_frame_buffer_if.slave bus
);
    localparam int unsigned AW    = TX_BUFFER_ADDR_WIDTH;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned TW    = $clog2(REQ_TIMEOUT) + 1;
    localparam int unsigned DEPTH = 2 ** AW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [15:0]          r_mem [0:2*DEPTH-1];

    logic [1:0]           r_state,       w_state_nxt;
    logic [1:0]           r_full,        w_full_nxt;
    logic [1:0][LW-1:0]   r_len,         w_len_nxt;
    logic                 r_wr_bank,     w_wr_bank_nxt;
    logic [LW-1:0]        r_wr_cnt,      w_wr_cnt_nxt;
    logic                 r_dropping,    w_dropping_nxt;
    logic                 r_rd_bank,     w_rd_bank_nxt;
    logic [TW-1:0]        r_timer,       w_timer_nxt;
    logic                 r_tx_req,      w_tx_req_nxt;
    logic [LW-1:0]        r_tx_len,      w_tx_len_nxt;
    logic                 r_frame_drop,  w_frame_drop_nxt;
    logic                 r_req_timeout, w_req_timeout_nxt;
    logic [15:0]          r_tx_data;

    logic w_s_ready;
    logic w_xfer;
    logic w_wr_en;
    logic w_rd_en;

    // While discarding an overflowed frame the stream is always accepted.
    assign w_s_ready = !r_full[r_wr_bank] || r_dropping;
    assign w_xfer    = bus.s_valid && w_s_ready;
    assign w_wr_en   = w_xfer && !r_dropping;
    assign w_rd_en   = (r_state == ST_REQ) || (r_state == ST_SEND);

    // Next-state logic for the write side and the TX request FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_full_nxt        = r_full;
        w_len_nxt         = r_len;
        w_wr_bank_nxt     = r_wr_bank;
        w_wr_cnt_nxt      = r_wr_cnt;
        w_dropping_nxt    = r_dropping;
        w_rd_bank_nxt     = r_rd_bank;
        w_timer_nxt       = r_timer;
        w_tx_req_nxt      = r_tx_req;
        w_tx_len_nxt      = r_tx_len;
        w_frame_drop_nxt  = 1'b0;
        w_req_timeout_nxt = 1'b0;

        if (w_xfer) begin
            if (r_dropping) begin
                if (bus.s_last) begin
                    w_dropping_nxt = 1'b0;
                end
            end else if (bus.s_last) begin
                w_full_nxt[r_wr_bank] = 1'b1;
                w_len_nxt[r_wr_bank]  = r_wr_cnt + LW'(1);
                w_wr_bank_nxt         = !r_wr_bank;
                w_wr_cnt_nxt          = '0;
            end else if (r_wr_cnt == LW'(DEPTH - 1)) begin
                // Bank filled without a frame end: discard the rest, reuse the bank.
                w_frame_drop_nxt = 1'b1;
                w_dropping_nxt   = 1'b1;
                w_wr_cnt_nxt     = '0;
            end else begin
                w_wr_cnt_nxt = r_wr_cnt + LW'(1);
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (r_full[r_rd_bank] && bus.busy_n) begin
                    w_state_nxt  = ST_REQ;
                    w_tx_req_nxt = 1'b1;
                    w_tx_len_nxt = r_len[r_rd_bank];
                    w_timer_nxt  = '0;
                end
            end
            ST_REQ: begin
                if (!bus.busy_n) begin
                    w_state_nxt  = ST_SEND;
                    w_tx_req_nxt = 1'b0;
                end else if (r_timer == TW'(REQ_TIMEOUT - 1)) begin
                    w_req_timeout_nxt     = 1'b1;
                    w_tx_req_nxt          = 1'b0;
                    w_full_nxt[r_rd_bank] = 1'b0;
                    w_rd_bank_nxt         = !r_rd_bank;
                    w_state_nxt           = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_SEND: begin
                if (bus.busy_n) begin
                    w_full_nxt[r_rd_bank] = 1'b0;
                    w_rd_bank_nxt         = !r_rd_bank;
                    w_state_nxt           = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_full        <= '0;
            r_len         <= '0;
            r_wr_bank     <= 1'b0;
            r_wr_cnt      <= '0;
            r_dropping    <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_timer       <= '0;
            r_tx_req      <= 1'b0;
            r_tx_len      <= '0;
            r_frame_drop  <= 1'b0;
            r_req_timeout <= 1'b0;
            r_tx_data     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_full        <= w_full_nxt;
            r_len         <= w_len_nxt;
            r_wr_bank     <= w_wr_bank_nxt;
            r_wr_cnt      <= w_wr_cnt_nxt;
            r_dropping    <= w_dropping_nxt;
            r_rd_bank     <= w_rd_bank_nxt;
            r_timer       <= w_timer_nxt;
            r_tx_req      <= w_tx_req_nxt;
            r_tx_len      <= w_tx_len_nxt;
            r_frame_drop  <= w_frame_drop_nxt;
            r_req_timeout <= w_req_timeout_nxt;
            if (w_rd_en) begin
                r_tx_data <= r_mem[{r_rd_bank, bus.tx_buffer_addr}];
            end
        end
    end

    // Frame storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{r_wr_bank, r_wr_cnt[AW-1:0]}] <= bus.s_data;
        end
    end

    assign bus.s_ready     = w_s_ready;
    assign bus.tx_req      = r_tx_req;
    assign bus.tx_data     = r_tx_data;
    assign bus.tx_len      = r_tx_len;
    assign bus.frame_drop  = r_frame_drop;
    assign bus.req_timeout = r_req_timeout;
endmodule

// File: tb/tb_w5300_tx_frame_buffer.sv
// Bench for w5300_tx_frame_buffer (AW=4, REQ_TIMEOUT=8): directed scenarios plus
// random frames checked against a frame-queue model of what the entry block must see.
module tb_w5300_tx_frame_buffer;
    localparam int unsigned AW = 4;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RT = 8;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   drop_cnt = 0;
    int   to_cnt   = 0;
    int   rise_cnt = 0;
    bit   prev_req = 0;
    logic [15:0] words [0:511];

    w5300_tx_frame_buffer_if #(.AW(AW)) bus ();

    w5300_tx_frame_buffer #(
        .TX_BUFFER_ADDR_WIDTH(AW),
        .REQ_TIMEOUT(RT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_drop === 1'b1) drop_cnt++;
        if (bus.req_timeout === 1'b1) to_cnt++;
        if (bus.tx_req === 1'b1 && !prev_req) rise_cnt++;
        prev_req = (bus.tx_req === 1'b1);
    end

    task automatic fill(input int base, input int len);
        for (int i = 0; i < len; i++) words[base+i] = 16'($urandom);
    endtask

    // Offer one word; it transfers at the next posedge if s_ready is seen high.
    task automatic push(input logic [15:0] d, input bit last, input int budget, output bit ok);
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        while (!bus.s_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.s_ready === 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int len, input bit strict, input int gapmax,
                              output bit all_ok);
        bit ok;
        all_ok = 1'b1;
        for (int i = 0; i < len; i++) begin
            push(words[base+i], (i == len - 1), strict ? 0 : 500, ok);
            if (!ok) all_ok = 1'b0;
            repeat ($urandom_range(0, gapmax)) @(negedge clk);
        end
    endtask

    // Entry-block emulation: take the request, read the whole frame, go idle.
    task automatic serve(input int base, input int len, input int delay);
        int n = 0;
        int off;
        while (bus.tx_req !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.tx_req !== 1'b1) begin
            bad++;
            $display("FAIL serve_req_wait: tx_req=%b expected 1 (frame base %0d)", bus.tx_req, base);
            return;
        end
        total++;
        if (bus.tx_len !== LW'(len)) begin
            bad++;
            $display("FAIL serve_tx_len: got %0d expected %0d", bus.tx_len, len);
        end
        repeat (delay) @(negedge clk);
        bus.busy_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.tx_req !== 1'b0) begin
            bad++;
            $display("FAIL serve_req_fall: tx_req=%b expected 0", bus.tx_req);
        end
        off = $urandom_range(0, len - 1);
        for (int i = 0; i < len; i++) begin
            int a;
            a = (i + off) % len;
            bus.tx_buffer_addr = AW'(a);
            @(negedge clk);
            total++;
            if (bus.tx_data !== words[base+a]) begin
                bad++;
                $display("FAIL serve_data[%0d]: got %h expected %h", a, bus.tx_data, words[base+a]);
            end
        end
        bus.busy_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_last = 1'b0;
        bus.tx_buffer_addr = '0;
        bus.busy_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        total += 6;
        if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b expected 1", bus.s_ready); end
        if (bus.tx_req !== 1'b0) begin bad++; $display("FAIL reset_tx_req: got %b expected 0", bus.tx_req); end
        if (bus.tx_data !== 16'h0) begin bad++; $display("FAIL reset_tx_data: got %h expected 0", bus.tx_data); end
        if (bus.tx_len !== LW'(0)) begin bad++; $display("FAIL reset_tx_len: got %0d expected 0", bus.tx_len); end
        if (bus.frame_drop !== 1'b0) begin bad++; $display("FAIL reset_frame_drop: got %b expected 0", bus.frame_drop); end
        if (bus.req_timeout !== 1'b0) begin bad++; $display("FAIL reset_req_timeout: got %b expected 0", bus.req_timeout); end
    endtask

    task automatic test_single_frame();
        bit ok;
        for (int i = 0; i < 4; i++) words[i] = 16'(16'h1111 * (i + 1));
        send_frame(0, 4, 1'b1, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_accept: s_ready low during frame, expected 1"); end
        total++;
        if (bus.tx_req !== 1'b0) begin bad++; $display("FAIL single_req_early: got %b expected 0", bus.tx_req); end
        @(negedge clk);
        total += 2;
        if (bus.tx_req !== 1'b1) begin bad++; $display("FAIL single_req_rise: got %b expected 1", bus.tx_req); end
        if (bus.tx_len !== LW'(4)) begin bad++; $display("FAIL single_tx_len: got %0d expected 4", bus.tx_len); end
        bus.busy_n = 1'b0;
        bus.tx_buffer_addr = AW'(2);
        @(negedge clk);
        total++;
        if (bus.tx_req !== 1'b0) begin bad++; $display("FAIL single_req_fall: got %b expected 0", bus.tx_req); end
        @(negedge clk);
        total++;
        if (bus.tx_data !== 16'h3333) begin bad++; $display("FAIL single_tx_data: got %h expected 3333", bus.tx_data); end
        bus.busy_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n = 0;
        fill(20, 3);
        fill(30, 5);
        fill(40, 2);
        send_frame(20, 3, 1'b1, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_first_accept: s_ready low, expected 1"); end
        while (bus.tx_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (bus.tx_len !== LW'(3) || bus.tx_req !== 1'b1) begin
            bad++; $display("FAIL b2b_first_req: req=%b len=%0d expected 1/3", bus.tx_req, bus.tx_len);
        end
        bus.busy_n = 1'b0;
        @(negedge clk);
        send_frame(30, 5, 1'b1, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_second_accept: s_ready low, expected 1"); end
        bus.s_valid = 1'b1;
        bus.s_data = words[40];
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall: s_ready=%b expected 0", bus.s_ready); end
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        for (int a = 0; a < 3; a++) begin
            bus.tx_buffer_addr = AW'(a);
            @(negedge clk);
            total++;
            if (bus.tx_data !== words[20+a]) begin
                bad++; $display("FAIL b2b_first_data[%0d]: got %h expected %h", a, bus.tx_data, words[20+a]);
            end
        end
        bus.busy_n = 1'b1;
        send_frame(40, 2, 1'b0, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_third_accept: not accepted after release"); end
        serve(30, 5, 0);
        serve(40, 2, 0);
    endtask

    task automatic test_overflow();
        bit ok;
        bit all_ok = 1'b1;
        int d0 = drop_cnt;
        int r0 = rise_cnt;
        fill(50, 19);
        fill(70, 2);
        for (int i = 0; i < 19; i++) begin
            push(words[50+i], (i == 18), 0, ok);
            if (!ok) all_ok = 1'b0;
            if (i == 15) begin
                total++;
                if (bus.frame_drop !== 1'b1) begin bad++; $display("FAIL ovf_drop_pulse: got %b expected 1", bus.frame_drop); end
            end
        end
        total++;
        if (!all_ok) begin bad++; $display("FAIL ovf_accept: s_ready low while discarding, expected 1"); end
        repeat (4) @(negedge clk);
        #1;
        total += 2;
        if (drop_cnt - d0 !== 1) begin bad++; $display("FAIL ovf_drop_count: got %0d expected 1", drop_cnt - d0); end
        if (rise_cnt - r0 !== 0) begin bad++; $display("FAIL ovf_no_req: got %0d expected 0", rise_cnt - r0); end
        send_frame(70, 2, 1'b1, 0, ok);
        serve(70, 2, 0);
    endtask

    task automatic test_exact_full();
        bit ok;
        int d0 = drop_cnt;
        fill(80, 16);
        send_frame(80, 16, 1'b1, 0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL full16_accept: s_ready low, expected 1"); end
        serve(80, 16, 1);
        #1;
        total++;
        if (drop_cnt !== d0) begin bad++; $display("FAIL full16_drop: got %0d expected %0d", drop_cnt, d0); end
    endtask

    task automatic test_random();
        int flen[8];
        int fbase[8];
        int exp_drops = 0;
        int d0 = drop_cnt;
        int t0 = to_cnt;
        int b = 256;
        for (int i = 0; i < 8; i++) begin
            flen[i] = $urandom_range(1, 20);
            if (i == 2) flen[i] = 19;
            if (i == 5) flen[i] = 16;
            fbase[i] = b;
            fill(b, flen[i]);
            b += flen[i];
            if (flen[i] > 16) exp_drops++;
        end
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bit ok;
                    send_frame(fbase[i], flen[i], 1'b0, 2, ok);
                    total++;
                    if (!ok) begin bad++; $display("FAIL rand_accept[%0d]: frame not accepted", i); end
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    if (flen[i] <= 16) serve(fbase[i], flen[i], $urandom_range(0, 3));
                end
            end
        join
        repeat (3) @(negedge clk);
        #1;
        total += 2;
        if (drop_cnt - d0 !== exp_drops) begin bad++; $display("FAIL rand_drops: got %0d expected %0d", drop_cnt - d0, exp_drops); end
        if (to_cnt - t0 !== 0) begin bad++; $display("FAIL rand_timeouts: got %0d expected 0", to_cnt - t0); end
    endtask

    task automatic test_timeout();
        bit ok;
        int k = 0;
        int t0 = to_cnt;
        fill(430, 3);
        fill(440, 2);
        bus.busy_n = 1'b0;
        send_frame(430, 3, 1'b1, 0, ok);
        send_frame(440, 2, 1'b1, 0, ok);
        @(negedge clk);
        bus.busy_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.tx_req !== 1'b1 || bus.tx_len !== LW'(3)) begin
            bad++; $display("FAIL to_req: req=%b len=%0d expected 1/3", bus.tx_req, bus.tx_len);
        end
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (bus.req_timeout === 1'b1) break;
        end
        total += 2;
        if (k !== 8) begin bad++; $display("FAIL to_latency: got %0d cycles expected 8", k); end
        if (bus.tx_req !== 1'b0) begin bad++; $display("FAIL to_req_fall: got %b expected 0", bus.tx_req); end
        serve(440, 2, 0);
        #1;
        total++;
        if (to_cnt - t0 !== 1) begin bad++; $display("FAIL to_count: got %0d expected 1", to_cnt - t0); end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int n = 0;
        int r0;
        fill(450, 2);
        fill(460, 3);
        bus.busy_n = 1'b0;
        send_frame(450, 2, 1'b1, 0, ok);
        send_frame(460, 3, 1'b1, 0, ok);
        bus.busy_n = 1'b1;
        while (bus.tx_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        bus.busy_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total += 5;
        if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL rst_send_s_ready: got %b expected 1", bus.s_ready); end
        if (bus.tx_req !== 1'b0) begin bad++; $display("FAIL rst_send_tx_req: got %b expected 0", bus.tx_req); end
        if (bus.tx_data !== 16'h0) begin bad++; $display("FAIL rst_send_tx_data: got %h expected 0", bus.tx_data); end
        if (bus.tx_len !== LW'(0)) begin bad++; $display("FAIL rst_send_tx_len: got %0d expected 0", bus.tx_len); end
        if (bus.frame_drop !== 1'b0 || bus.req_timeout !== 1'b0) begin
            bad++; $display("FAIL rst_send_pulses: drop=%b to=%b expected 0/0", bus.frame_drop, bus.req_timeout);
        end
        rst_n = 1'b1;
        bus.busy_n = 1'b1;
        #1;
        r0 = rise_cnt;
        repeat (12) @(negedge clk);
        #1;
        total++;
        if (rise_cnt !== r0) begin bad++; $display("FAIL rst_send_no_req: got %0d requests expected 0", rise_cnt - r0); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_exact_full();
        test_random();
        test_timeout();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
